// File: rtl/mips_pipelined_core.sv
// mips_pipelined_core: 5-stage pipelined MIPS core (F/D/E/M/W) with forwarding,
// load-use and branch stalls, and F/D flush on taken beq or j.
module instruction_mem #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic [AW-1:0] a,
    output logic [31:0]   rd
);
    logic [31:0] I_mem [DEPTH];
    assign rd = I_mem[a];
endmodule

module data_mem #(
    parameter int DEPTH = 256,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] a,
    input  logic [31:0]   wd,
    output logic [31:0]   rd
);
    logic [31:0] D_mem [DEPTH];
    always_ff @(posedge clk)
        if (we) D_mem[a] <= wd;
    assign rd = D_mem[a];
endmodule

module regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] reg_file [32];
    // Negedge write lets a D-stage read see the value written by W in the same cycle
    always_ff @(negedge clk)
        if (we && a3 != 5'd0) reg_file[a3] <= wd3;
    assign rd1 = a1 == 5'd0 ? 32'd0 : reg_file[a1];
    assign rd2 = a2 == 5'd0 ? 32'd0 : reg_file[a2];
endmodule

module mips_pipelined_core #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110, ALU_SLT = 3'b111;

    logic [31:0] pcf, instr_f, pcplus4_f, pc_next, Instr_D, PCPlus4D;
    logic [31:0] rd1_d, rd2_d, signimm_d, pc_branch_d, pc_jump_d, cmp_a, cmp_b;
    logic [5:0]  op_d, funct_d;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic        is_r, r_valid, is_lw, is_sw, is_addi, branch_d, jump_d, pcsrc_d;
    logic        reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d;
    logic [2:0]  alu_ctrl_d;
    logic        lw_stall, branch_stall, stall, redirect;

    logic        reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
    logic [2:0]  alu_ctrl_e;
    logic [31:0] rd1_e, rd2_e, signimm_e, src_a_e, src_b_e, write_data_e, alu_out_e;
    logic [4:0]  rs_e, rt_e, rd_e, write_reg_e;

    logic        reg_write_m, mem_to_reg_m, mem_write_m;
    logic [31:0] alu_out_m, write_data_m, read_data_m;
    logic [4:0]  write_reg_m;

    logic        reg_write_w, mem_to_reg_w;
    logic [31:0] alu_out_w, read_data_w, WD_3;
    logic [4:0]  write_reg_w;

    assign pcplus4_f = pcf + 32'd4;

    instruction_mem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) Instruction_mem_inst (
        .a(pcf[IAW+1:2]), .rd(instr_f)
    );

    always_ff @(posedge clk)
        if (rst) pcf <= '0;
        else if (!stall) pcf <= pc_next;

    always_ff @(posedge clk)
        if (rst || redirect) {Instr_D, PCPlus4D} <= '0;
        else if (!stall) {Instr_D, PCPlus4D} <= {instr_f, pcplus4_f};

    assign op_d      = Instr_D[31:26];
    assign funct_d   = Instr_D[5:0];
    assign rs_d      = Instr_D[25:21];
    assign rt_d      = Instr_D[20:16];
    assign rd_d      = Instr_D[15:11];
    assign signimm_d = {{16{Instr_D[15]}}, Instr_D[15:0]};

    assign is_r     = op_d == 6'h00;
    assign r_valid  = is_r && (funct_d inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a});
    assign is_lw    = op_d == 6'h23;
    assign is_sw    = op_d == 6'h2b;
    assign is_addi  = op_d == 6'h08;
    assign branch_d = op_d == 6'h04;
    assign jump_d   = op_d == 6'h02;

    assign reg_write_d  = r_valid | is_lw | is_addi;
    assign mem_to_reg_d = is_lw;
    assign mem_write_d  = is_sw;
    assign alu_src_d    = is_lw | is_sw | is_addi;
    assign reg_dst_d    = is_r;
    assign alu_ctrl_d   = !is_r ? ALU_ADD : funct_d == 6'h22 ? ALU_SUB : funct_d == 6'h24 ? ALU_AND :
                          funct_d == 6'h25 ? ALU_OR : funct_d == 6'h2a ? ALU_SLT : ALU_ADD;

    regfile Reg_File_inst (
        .clk(clk), .we(reg_write_w && !rst), .a1(rs_d), .a2(rt_d), .a3(write_reg_w),
        .wd3(WD_3), .rd1(rd1_d), .rd2(rd2_d)
    );

    assign cmp_a       = (rs_d != 5'd0 && rs_d == write_reg_m && reg_write_m) ? alu_out_m : rd1_d;
    assign cmp_b       = (rt_d != 5'd0 && rt_d == write_reg_m && reg_write_m) ? alu_out_m : rd2_d;
    assign pcsrc_d     = branch_d && cmp_a == cmp_b;
    assign pc_branch_d = PCPlus4D + {signimm_d[29:0], 2'b00};
    assign pc_jump_d   = {PCPlus4D[31:28], Instr_D[25:0], 2'b00};
    assign pc_next     = pcsrc_d ? pc_branch_d : jump_d ? pc_jump_d : pcplus4_f;

    assign lw_stall     = mem_to_reg_e && (rt_e == rs_d || rt_e == rt_d);
    assign branch_stall = branch_d && ((reg_write_e && (write_reg_e == rs_d || write_reg_e == rt_d)) ||
                                       (mem_to_reg_m && (write_reg_m == rs_d || write_reg_m == rt_d)));
    assign stall        = lw_stall | branch_stall;
    // A stalled beq may have compared stale operands, so it must not redirect
    assign redirect     = !stall && (pcsrc_d || jump_d);

    always_ff @(posedge clk)
        {reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e, alu_ctrl_e,
         rd1_e, rd2_e, rs_e, rt_e, rd_e, signimm_e} <= (rst || stall) ? '0 :
        {reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d, alu_ctrl_d,
         rd1_d, rd2_d, rs_d, rt_d, rd_d, signimm_d};

    assign src_a_e      = (rs_e != 5'd0 && rs_e == write_reg_m && reg_write_m) ? alu_out_m :
                          (rs_e != 5'd0 && rs_e == write_reg_w && reg_write_w) ? WD_3 : rd1_e;
    assign write_data_e = (rt_e != 5'd0 && rt_e == write_reg_m && reg_write_m) ? alu_out_m :
                          (rt_e != 5'd0 && rt_e == write_reg_w && reg_write_w) ? WD_3 : rd2_e;
    assign src_b_e      = alu_src_e ? signimm_e : write_data_e;
    assign write_reg_e  = reg_dst_e ? rd_e : rt_e;
    assign alu_out_e    = alu_ctrl_e == ALU_AND ? src_a_e & src_b_e :
                          alu_ctrl_e == ALU_OR  ? src_a_e | src_b_e :
                          alu_ctrl_e == ALU_SUB ? src_a_e - src_b_e :
                          alu_ctrl_e == ALU_SLT ? {31'd0, $signed(src_a_e) < $signed(src_b_e)} :
                          src_a_e + src_b_e;

    always_ff @(posedge clk)
        {reg_write_m, mem_to_reg_m, mem_write_m, alu_out_m, write_data_m, write_reg_m} <= rst ? '0 :
        {reg_write_e, mem_to_reg_e, mem_write_e, alu_out_e, write_data_e, write_reg_e};

    data_mem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) Data_mem_inst (
        .clk(clk), .we(mem_write_m && !rst), .a(alu_out_m[DAW+1:2]), .wd(write_data_m), .rd(read_data_m)
    );

    always_ff @(posedge clk)
        {reg_write_w, mem_to_reg_w, alu_out_w, read_data_w, write_reg_w} <= rst ? '0 :
        {reg_write_m, mem_to_reg_m, alu_out_m, read_data_m, write_reg_m};

    assign WD_3 = mem_to_reg_w ? read_data_w : alu_out_w;
endmodule

// File: tb/tb_mips_pipelined_core.sv
// tb_mips_pipelined_core: directed programs with hand-computed pipeline timing;
// edge N means N posedges after reset is released.
module tb_mips_pipelined_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;

    mips_pipelined_core dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic begin_test();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            dut.Instruction_mem_inst.I_mem[i] = 32'd0;
            dut.Data_mem_inst.D_mem[i] = 32'd0;
        end
        for (int i = 0; i < 32; i++) dut.Reg_File_inst.reg_file[i] = 32'd0;
    endtask

    task automatic release_reset(input string tag);
        step();
        check({tag, " rst pcf"}, dut.pcf, 32'd0);
        check({tag, " rst instr_d"}, dut.Instr_D, 32'd0);
        step();
        rst = 1'b0;
    endtask

    logic [31:0] w0, w1, w2, w3, w4;

    initial begin
        // 1: single addi after reset
        begin_test();
        w0 = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        dut.Instruction_mem_inst.I_mem[0] = w0;
        release_reset("t1");
        step();
        check("t1 instr_d e1", dut.Instr_D, w0);
        check("t1 pcf e1", dut.pcf, 32'd4);
        step();
        check("t1 pcf e2", dut.pcf, 32'd8);
        step(2);
        check("t1 wd3 e4", dut.WD_3, 32'd5);
        step();
        check("t1 reg1", dut.Reg_File_inst.reg_file[1], 32'd5);

        // 2: back-to-back dependency via forwarding
        begin_test();
        dut.Reg_File_inst.reg_file[1] = 32'd5;
        dut.Reg_File_inst.reg_file[2] = 32'd7;
        dut.Instruction_mem_inst.I_mem[0] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        dut.Instruction_mem_inst.I_mem[1] = enc_r(5'd3, 5'd1, 5'd4, 6'h22);
        release_reset("t2");
        step(4);
        check("t2 wd3 add", dut.WD_3, 32'd12);
        check("t2 pcf no stall", dut.pcf, 32'd16);
        step();
        check("t2 wd3 sub", dut.WD_3, 32'd7);
        step();
        check("t2 reg3", dut.Reg_File_inst.reg_file[3], 32'd12);
        check("t2 reg4", dut.Reg_File_inst.reg_file[4], 32'd7);

        // 3: load-use stall
        begin_test();
        dut.Data_mem_inst.D_mem[1] = 32'd9;
        w1 = enc_r(5'd5, 5'd5, 5'd6, 6'h20);
        dut.Instruction_mem_inst.I_mem[0] = enc_i(6'h23, 5'd0, 5'd5, 16'd4);
        dut.Instruction_mem_inst.I_mem[1] = w1;
        release_reset("t3");
        step(3);
        check("t3 pcf held", dut.pcf, 32'd8);
        check("t3 instr_d held", dut.Instr_D, w1);
        step();
        check("t3 wd3 lw", dut.WD_3, 32'd9);
        check("t3 pcf resumes", dut.pcf, 32'd12);
        step(2);
        check("t3 wd3 add", dut.WD_3, 32'd18);
        step();
        check("t3 reg6", dut.Reg_File_inst.reg_file[6], 32'd18);

        // 4: taken beq flushes one slot, untaken beq falls through
        begin_test();
        dut.Reg_File_inst.reg_file[1] = 32'd5;
        dut.Reg_File_inst.reg_file[2] = 32'd7;
        w0 = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
        w3 = enc_i(6'h04, 5'd1, 5'd2, 16'd5);
        w4 = enc_i(6'h08, 5'd0, 5'd10, 16'd3);
        dut.Instruction_mem_inst.I_mem[0] = w0;
        dut.Instruction_mem_inst.I_mem[1] = enc_i(6'h08, 5'd0, 5'd8, 16'd1);
        dut.Instruction_mem_inst.I_mem[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd2);
        dut.Instruction_mem_inst.I_mem[3] = w3;
        dut.Instruction_mem_inst.I_mem[4] = w4;
        release_reset("t4");
        step();
        check("t4 instr_d beq", dut.Instr_D, w0);
        step();
        check("t4 pcf target", dut.pcf, 32'd12);
        check("t4 flushed slot", dut.Instr_D, 32'd0);
        step();
        check("t4 instr_d beq2", dut.Instr_D, w3);
        step();
        check("t4 pcf untaken", dut.pcf, 32'd20);
        check("t4 instr_d addi", dut.Instr_D, w4);
        step(3);
        check("t4 wd3 addi", dut.WD_3, 32'd3);
        step();
        check("t4 reg10", dut.Reg_File_inst.reg_file[10], 32'd3);
        check("t4 reg8 skipped", dut.Reg_File_inst.reg_file[8], 32'd0);
        check("t4 reg9 skipped", dut.Reg_File_inst.reg_file[9], 32'd0);

        // 5: sw/lw round trip, j loops back to 0
        begin_test();
        dut.Reg_File_inst.reg_file[2] = 32'd7;
        w0 = enc_i(6'h2b, 5'd0, 5'd2, 16'd8);
        w2 = {6'h02, 26'd0};
        dut.Instruction_mem_inst.I_mem[0] = w0;
        dut.Instruction_mem_inst.I_mem[1] = enc_i(6'h23, 5'd0, 5'd7, 16'd8);
        dut.Instruction_mem_inst.I_mem[2] = w2;
        dut.Instruction_mem_inst.I_mem[3] = enc_i(6'h08, 5'd0, 5'd11, 16'd1);
        release_reset("t5");
        step(3);
        check("t5 instr_d j", dut.Instr_D, w2);
        step();
        check("t5 pcf jump", dut.pcf, 32'd0);
        check("t5 jump flush", dut.Instr_D, 32'd0);
        step();
        check("t5 instr_d loop", dut.Instr_D, w0);
        check("t5 wd3 lw", dut.WD_3, 32'd7);
        step();
        check("t5 dmem2", dut.Data_mem_inst.D_mem[2], 32'd7);
        check("t5 reg7", dut.Reg_File_inst.reg_file[7], 32'd7);
        check("t5 reg11 flushed", dut.Reg_File_inst.reg_file[11], 32'd0);

        // 6: $0 write ignored, signed slt, mid-run reset
        begin_test();
        w0 = enc_i(6'h08, 5'd0, 5'd0, 16'd3);
        dut.Instruction_mem_inst.I_mem[0] = w0;
        dut.Instruction_mem_inst.I_mem[1] = enc_i(6'h08, 5'd0, 5'd16, 16'd4);
        dut.Instruction_mem_inst.I_mem[2] = enc_i(6'h08, 5'd0, 5'd12, 16'hffff);
        dut.Instruction_mem_inst.I_mem[3] = enc_i(6'h08, 5'd0, 5'd13, 16'd1);
        dut.Instruction_mem_inst.I_mem[4] = enc_r(5'd12, 5'd13, 5'd14, 6'h2a);
        release_reset("t6");
        step(5);
        check("t6 wd3 addi after $0", dut.WD_3, 32'd4);
        step(3);
        check("t6 wd3 slt", dut.WD_3, 32'd1);
        step(2);
        check("t6 reg0", dut.Reg_File_inst.reg_file[0], 32'd0);
        check("t6 reg16", dut.Reg_File_inst.reg_file[16], 32'd4);
        check("t6 reg12", dut.Reg_File_inst.reg_file[12], 32'hffffffff);
        check("t6 reg14", dut.Reg_File_inst.reg_file[14], 32'd1);
        rst = 1'b1;
        step();
        check("t6 midrun pcf", dut.pcf, 32'd0);
        check("t6 midrun instr_d", dut.Instr_D, 32'd0);
        rst = 1'b0;
        step();
        check("t6 refetch pcf", dut.pcf, 32'd4);
        check("t6 refetch instr_d", dut.Instr_D, w0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
